// File: rtl/l2_cache_control_if.sv
// l2_cache_control_if
//   Bundles every signal between the L2 sequencing FSM and its neighbours:
//   the L1 arbiter request/response pair, the datapath flags and load
//   strobes, and the physical memory port.
//
//   Handshakes (both sides of the controller):
//     - The arbiter raises mem_read or mem_write and holds it, with the
//       address and data stable, until it sees mem_resp. mem_resp is high for
//       exactly one cycle, and the arbiter drops its request at that edge.
//     - The controller raises pmem_read or pmem_write (never both) and holds
//       it, with pmemaddr_sel and pmemwdata_sel stable, until pmem_resp. The
//       access completes on the clock edge that ends the pmem_resp cycle.
//
//   Modports:
//     slave  - the controller (l2_cache_control)
//     master - the environment (arbiter, datapath, physical memory)
interface l2_cache_control_if;
  // arbiter side
  logic       mem_read;
  logic       mem_write;
  logic       mem_resp;
  // datapath side
  logic [7:0] way_hit;
  logic [7:0] way_dirty;
  logic [6:0] lru_out;
  logic [6:0] lru_in;
  logic       load_lru;
  logic [7:0] load_td;
  logic [7:0] load_v;
  logic [7:0] load_d;
  logic       v_in;
  logic       d_in;
  logic [2:0] pmemwdata_sel;
  logic [3:0] pmemaddr_sel;
  // physical memory side
  logic       pmem_read;
  logic       pmem_write;
  logic       pmem_resp;

  modport slave (
    input  mem_read, mem_write, way_hit, way_dirty, lru_out, pmem_resp,
    output mem_resp, lru_in, load_lru, load_td, load_v, load_d, v_in, d_in,
           pmemwdata_sel, pmemaddr_sel, pmem_read, pmem_write
  );

  modport master (
    output mem_read, mem_write, way_hit, way_dirty, lru_out, pmem_resp,
    input  mem_resp, lru_in, load_lru, load_td, load_v, load_d, v_in, d_in,
           pmemwdata_sel, pmemaddr_sel, pmem_read, pmem_write
  );
endinterface

// File: rtl/l2_cache_control.sv
// l2_cache_control
//   Sequencing FSM for the 8-way L2 cache datapath. Serves one arbiter
//   request at a time, resolves hit/miss from the datapath way flags,
//   maintains the 7-bit tree pseudo-LRU of the indexed set, and on a miss
//   writes back a dirty victim before allocating the line from memory.
//
//   Ports:
//     clk       - clock
//     rst_n     - asynchronous active-low reset
//     bus       - l2_cache_control_if.slave (arbiter, datapath, pmem signals)
//     dbg_state - current FSM state (0 IDLE, 1 LOOKUP, 2 WRITEBACK, 3 ALLOCATE)
module l2_cache_control (
  input  logic               clk,
  input  logic               rst_n,
  l2_cache_control_if.slave  bus,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    WRITEBACK = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] victim_q, victim_d;

  logic       hit;
  logic [2:0] hit_way;
  logic [2:0] plru_victim;
  logic [6:0] lru_upd;
  logic       req;

  assign req       = bus.mem_read | bus.mem_write;
  assign hit       = |bus.way_hit;
  assign dbg_state = state_q;

  // Lowest set way wins if the datapath ever reports more than one hit.
  always_comb begin
    hit_way = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.way_hit[i]) hit_way = 3'(i);
    end
  end

  // Walk the tree: root picks the half, level 1 the pair, leaf the way.
  always_comb begin
    plru_victim    = 3'd0;
    plru_victim[2] = bus.lru_out[0];
    plru_victim[1] = bus.lru_out[0] ? bus.lru_out[2] : bus.lru_out[1];
    plru_victim[0] = bus.lru_out[3'd3 + {1'b0, plru_victim[2:1]}];
  end

  // Point every node on the accessed way's path away from it.
  always_comb begin
    lru_upd                                 = bus.lru_out;
    lru_upd[0]                              = ~hit_way[2];
    lru_upd[3'd1 + {2'b00, hit_way[2]}]     = ~hit_way[1];
    lru_upd[3'd3 + {1'b0, hit_way[2:1]}]    = ~hit_way[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      victim_q <= 3'd0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    victim_d          = victim_q;
    bus.mem_resp      = 1'b0;
    bus.lru_in        = 7'd0;
    bus.load_lru      = 1'b0;
    bus.load_td       = 8'd0;
    bus.load_v        = 8'd0;
    bus.load_d        = 8'd0;
    bus.v_in          = 1'b0;
    bus.d_in          = 1'b0;
    bus.pmemwdata_sel = 3'd0;
    bus.pmemaddr_sel  = 4'd0;
    bus.pmem_read     = 1'b0;
    bus.pmem_write    = 1'b0;

    case (state_q)
      IDLE: begin
        if (req) state_d = LOOKUP;
      end

      LOOKUP: begin
        if (!req) begin
          // Request vanished (protocol violation); nothing to complete.
          state_d = IDLE;
        end else if (hit) begin
          bus.pmemwdata_sel = hit_way;
          bus.mem_resp      = 1'b1;
          bus.load_lru      = 1'b1;
          bus.lru_in        = lru_upd;
          // A simultaneous read+write is served as a write.
          if (bus.mem_write) begin
            bus.load_td = 8'b1 << hit_way;
            bus.load_d  = 8'b1 << hit_way;
            bus.d_in    = 1'b1;
          end
          state_d = IDLE;
        end else begin
          victim_d = plru_victim;
          state_d  = bus.way_dirty[plru_victim] ? WRITEBACK : ALLOCATE;
        end
      end

      WRITEBACK: begin
        bus.pmem_write    = 1'b1;
        bus.pmemwdata_sel = victim_q;
        bus.pmemaddr_sel  = 4'd1 + {1'b0, victim_q};
        if (bus.pmem_resp) state_d = ALLOCATE;
      end

      ALLOCATE: begin
        bus.pmem_read    = 1'b1;
        bus.pmemaddr_sel = 4'd0;
        if (bus.pmem_resp) begin
          // Fill a clean line; the re-lookup merges any write data.
          bus.load_td = 8'b1 << victim_q;
          bus.load_v  = 8'b1 << victim_q;
          bus.load_d  = 8'b1 << victim_q;
          bus.v_in    = 1'b1;
          bus.d_in    = 1'b0;
          state_d     = LOOKUP;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_l2_cache_control.sv
module tb_l2_cache_control;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOOKUP = 2'd1;
  localparam logic [1:0] S_WB     = 2'd2;
  localparam logic [1:0] S_ALLOC  = 2'd3;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  l2_cache_control_if bus();

  l2_cache_control dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  int total  = 0;
  int passed = 0;

  // pulse counters for the back-to-back sequence
  logic count_en = 1'b0;
  int   resp_cnt = 0;
  int   lru_cnt  = 0;

  always @(negedge clk) begin
    if (count_en) begin
      resp_cnt <= resp_cnt + int'(bus.mem_resp);
      lru_cnt  <= lru_cnt + int'(bus.load_lru);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  // Observation order:
  // {mem_resp, load_lru, lru_in, load_td, load_v, load_d, v_in, d_in,
  //  pmemwdata_sel, pmemaddr_sel, pmem_read, pmem_write}
  function automatic logic [43:0] mk(input logic resp, input logic ll,
                                     input logic [6:0] li, input logic [7:0] td,
                                     input logic [7:0] v, input logic [7:0] d,
                                     input logic vi, input logic di,
                                     input logic [2:0] ws, input logic [3:0] as,
                                     input logic pr, input logic pw);
    return {resp, ll, li, td, v, d, vi, di, ws, as, pr, pw};
  endfunction

  function automatic logic [43:0] obs();
    return {bus.mem_resp, bus.load_lru, bus.lru_in, bus.load_td, bus.load_v,
            bus.load_d, bus.v_in, bus.d_in, bus.pmemwdata_sel,
            bus.pmemaddr_sel, bus.pmem_read, bus.pmem_write};
  endfunction

  task automatic check_obs(input string name, input logic [43:0] exp);
    logic [43:0] act;
    act = obs();
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: outputs got %h expected %h", name, act, exp);
  endtask

  task automatic check_val(input string name, input logic [7:0] act,
                           input logic [7:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.mem_read  = 1'b0;
    bus.mem_write = 1'b0;
    bus.way_hit   = 8'd0;
    bus.way_dirty = 8'd0;
    bus.lru_out   = 7'd0;
    bus.pmem_resp = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) step();
    rst_n = 1'b1;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rd;
    logic       wr;
    logic [7:0] hit;
    logic [7:0] dirty;
    logic [6:0] lru;
    logic [43:0] exp;
    logic [1:0] nxt;
  } vec_t;

  vec_t vecs[10];

  initial begin
    // read hit way5, lru 0 -> bit2 set only
    vecs[0] = '{1'b1, 1'b0, 8'h20, 8'h00, 7'h00, mk(1,1,7'h04,8'h00,8'h00,8'h00,0,0,3'd5,4'd0,0,0), S_IDLE};
    // write hit way2, lru 0 -> bits {0,1,4} = {1,0,1}
    vecs[1] = '{1'b0, 1'b1, 8'h04, 8'h00, 7'h00, mk(1,1,7'h11,8'h04,8'h00,8'h04,0,1,3'd2,4'd0,0,0), S_IDLE};
    // read hit way7, lru all ones -> bits 0,2,6 cleared
    vecs[2] = '{1'b1, 1'b0, 8'h80, 8'h00, 7'h7F, mk(1,1,7'h3A,8'h00,8'h00,8'h00,0,0,3'd7,4'd0,0,0), S_IDLE};
    // double hit ways 3 and 5 -> way3 wins
    vecs[3] = '{1'b1, 1'b0, 8'h28, 8'h00, 7'h00, mk(1,1,7'h01,8'h00,8'h00,8'h00,0,0,3'd3,4'd0,0,0), S_IDLE};
    // read and write together -> served as a write, hit way0
    vecs[4] = '{1'b1, 1'b1, 8'h01, 8'h00, 7'h00, mk(1,1,7'h0B,8'h01,8'h00,8'h01,0,1,3'd0,4'd0,0,0), S_IDLE};
    // read miss, victim way0 clean
    vecs[5] = '{1'b1, 1'b0, 8'h00, 8'h00, 7'h00, 44'd0, S_ALLOC};
    // write miss, victim way7 dirty
    vecs[6] = '{1'b0, 1'b1, 8'h00, 8'h80, 7'h45, 44'd0, S_WB};
    // read miss, victim way7 clean while the other ways are dirty
    vecs[7] = '{1'b1, 1'b0, 8'h00, 8'h7F, 7'h45, 44'd0, S_ALLOC};
    // read miss, lru 0000110 -> victim way2, dirty
    vecs[8] = '{1'b1, 1'b0, 8'h00, 8'h04, 7'h06, 44'd0, S_WB};
    // write hit way6, lru 1010101 -> 1010000
    vecs[9] = '{1'b0, 1'b1, 8'h40, 8'h00, 7'h55, mk(1,1,7'h50,8'h40,8'h00,8'h40,0,1,3'd6,4'd0,0,0), S_IDLE};
  end

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #3;
    check_obs("reset_outputs", 44'd0);
    check_val("reset_state", {6'b0, dbg_state}, {6'b0, S_IDLE});
    repeat (2) step();
    rst_n = 1'b1;

    // table-driven single LOOKUP decisions
    for (int i = 0; i < 10; i++) begin
      do_reset();
      bus.mem_read  = vecs[i].rd;
      bus.mem_write = vecs[i].wr;
      bus.way_hit   = vecs[i].hit;
      bus.way_dirty = vecs[i].dirty;
      bus.lru_out   = vecs[i].lru;
      #1;
      check_obs($sformatf("vec%0d_idle", i), 44'd0);
      step();
      @(negedge clk);
      check_obs($sformatf("vec%0d_lookup", i), vecs[i].exp);
      step();
      bus.mem_read  = 1'b0;
      bus.mem_write = 1'b0;
      check_val($sformatf("vec%0d_next", i), {6'b0, dbg_state}, {6'b0, vecs[i].nxt});
    end

    // cold read miss: victim way0, clean allocate, re-lookup hit
    do_reset();
    bus.mem_read = 1'b1;
    step();
    @(negedge clk); check_obs("cold_lookup", 44'd0);
    step();
    @(negedge clk); check_obs("cold_alloc", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd0,4'd0,1,0));
    step();
    @(negedge clk); check_obs("cold_alloc_hold", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd0,4'd0,1,0));
    step();
    bus.pmem_resp = 1'b1;
    @(negedge clk); check_obs("cold_alloc_resp", mk(0,0,7'h00,8'h01,8'h01,8'h01,1,0,3'd0,4'd0,1,0));
    step();
    bus.pmem_resp = 1'b0;
    bus.way_hit   = 8'h01;
    check_val("cold_relookup_state", {6'b0, dbg_state}, {6'b0, S_LOOKUP});
    @(negedge clk); check_obs("cold_relookup", mk(1,1,7'h0B,8'h00,8'h00,8'h00,0,0,3'd0,4'd0,0,0));
    step();
    bus.mem_read = 1'b0;
    check_val("cold_done_state", {6'b0, dbg_state}, {6'b0, S_IDLE});

    // dirty write miss: writeback way7, allocate way7, write merge
    do_reset();
    bus.mem_write = 1'b1;
    bus.lru_out   = 7'h45;
    bus.way_dirty = 8'h80;
    step();
    @(negedge clk); check_obs("dirty_lookup", 44'd0);
    step();
    check_val("dirty_wb_state", {6'b0, dbg_state}, {6'b0, S_WB});
    @(negedge clk); check_obs("dirty_wb", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd7,4'd8,0,1));
    step();
    // the latched victim must survive datapath flags changing
    bus.lru_out   = 7'h00;
    bus.way_dirty = 8'h00;
    @(negedge clk); check_obs("dirty_wb_hold", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd7,4'd8,0,1));
    step();
    bus.pmem_resp = 1'b1;
    @(negedge clk); check_obs("dirty_wb_resp", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd7,4'd8,0,1));
    step();
    bus.pmem_resp = 1'b0;
    check_val("dirty_alloc_state", {6'b0, dbg_state}, {6'b0, S_ALLOC});
    @(negedge clk); check_obs("dirty_alloc", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd0,4'd0,1,0));
    step();
    bus.pmem_resp = 1'b1;
    @(negedge clk); check_obs("dirty_alloc_resp", mk(0,0,7'h00,8'h80,8'h80,8'h80,1,0,3'd0,4'd0,1,0));
    step();
    bus.pmem_resp = 1'b0;
    bus.way_hit   = 8'h80;
    bus.lru_out   = 7'h45;
    @(negedge clk); check_obs("dirty_relookup", mk(1,1,7'h00,8'h80,8'h00,8'h80,0,1,3'd7,4'd0,0,0));
    step();
    bus.mem_write = 1'b0;
    check_val("dirty_done_state", {6'b0, dbg_state}, {6'b0, S_IDLE});

    // asynchronous reset in the middle of ALLOCATE
    do_reset();
    bus.mem_read = 1'b1;
    step();
    step();
    @(negedge clk); check_obs("rst_alloc", mk(0,0,7'h00,8'h00,8'h00,8'h00,0,0,3'd0,4'd0,1,0));
    #2;
    rst_n = 1'b0;
    #1;
    check_obs("rst_async_outputs", 44'd0);
    check_val("rst_async_state", {6'b0, dbg_state}, {6'b0, S_IDLE});
    bus.way_hit = 8'h20;
    step();
    rst_n = 1'b1;
    check_val("rst_release_state", {6'b0, dbg_state}, {6'b0, S_IDLE});
    step();
    @(negedge clk); check_obs("rst_restart", mk(1,1,7'h04,8'h00,8'h00,8'h00,0,0,3'd5,4'd0,0,0));
    step();
    bus.mem_read = 1'b0;
    bus.way_hit  = 8'h00;
    // a stray pmem_resp in IDLE must be ignored
    bus.pmem_resp = 1'b1;
    #1;
    check_obs("stray_resp_outputs", 44'd0);
    step();
    bus.pmem_resp = 1'b0;
    check_val("stray_resp_state", {6'b0, dbg_state}, {6'b0, S_IDLE});

    // back-to-back: read hit way1, one idle cycle, write hit way6 same set
    do_reset();
    count_en      = 1'b1;
    bus.mem_read  = 1'b1;
    bus.way_hit   = 8'h02;
    bus.lru_out   = 7'h00;
    step();
    @(negedge clk); check_obs("b2b_read", mk(1,1,7'h03,8'h00,8'h00,8'h00,0,0,3'd1,4'd0,0,0));
    step();
    bus.mem_read = 1'b0;
    step();
    bus.mem_write = 1'b1;
    bus.way_hit   = 8'h40;
    bus.lru_out   = 7'h03;
    step();
    @(negedge clk); check_obs("b2b_write", mk(1,1,7'h42,8'h40,8'h00,8'h40,0,1,3'd6,4'd0,0,0));
    step();
    bus.mem_write = 1'b0;
    repeat (3) step();
    count_en = 1'b0;
    check_val("b2b_resp_pulses", 8'(resp_cnt), 8'd2);
    check_val("b2b_lru_pulses", 8'(lru_cnt), 8'd2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/l2_cache_control.md
Name: l2_cache_control

Overview:
- Sequencing FSM for the 8-way L2 cache datapath.
- Accepts one read or write request at a time from the L1 arbiter.
- Resolves hit or miss from the datapath's per-way hit and dirty flags, and maintains the 7-bit tree pseudo-LRU per set.
- On a miss, writes back a dirty victim and allocates the line from physical memory.

Parameters:
- None. Way count (8) and tree-PLRU width (7) are fixed by the datapath.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- mem_read  in  1  arbiter read request; held until mem_resp
- mem_write  in  1  arbiter write request; held until mem_resp
- mem_resp  out  1  one-cycle completion pulse to arbiter
- way_hit  in  8  per-way hit (valid & tag match) from datapath
- way_dirty  in  8  per-way dirty bit of indexed set
- lru_out  in  7  PLRU bits of indexed set
- lru_in  out  7  updated PLRU bits
- load_lru  out  1  write lru_in into indexed set
- load_td  out  8  per-way tag+data load
- load_v  out  8  per-way valid load
- load_d  out  8  per-way dirty load
- v_in  out  1  valid value written
- d_in  out  1  dirty value written
- pmemwdata_sel  out  3  way feeding pmem_wdata / l2_mem_rdata
- pmemaddr_sel  out  4  0 = request line address; 1+w = way w writeback address
- pmem_read  out  1  physical memory read (also selects pmem_rdata in write logic)
- pmem_write  out  1  physical memory write
- pmem_resp  in  1  physical memory completion

Behaviour:
- Reset: asynchronous, while rst_n=0. State = IDLE, victim register = 0. All outputs 0.
- Reset mid-transaction: any pmem access is abandoned. Tag/data/LRU arrays are untouched.
- Default outputs in every state are 0 unless listed below.
- Hit way index h = lowest set bit of way_hit. Multiple hits are illegal; lowest index wins.
- PLRU victim decode:
  - lru[0]=0 selects ways 0-3, else ways 4-7.
  - Next level: lru[1] (for 0-3) or lru[2] (for 4-7); 0 selects the lower pair.
  - Leaf: lru[3..6] for pairs 0/1, 2/3, 4/5, 6/7; 0 selects the lower way.
- PLRU update on access to way w, all other bits from lru_out:
  - lru[0] = ~w[2]
  - lru[1+w[2]] = ~w[1]
  - lru[3+w[2:1]] = ~w[0]
- IDLE:
  - mem_read or mem_write -> LOOKUP.
  - Both asserted together is illegal; treat as a write.
- LOOKUP (datapath outputs combinational, valid this cycle):
  - Hit, read: pmemwdata_sel=h, mem_resp=1, load_lru=1, lru_in=update(h) -> IDLE.
  - Hit, write: pmemwdata_sel=h, load_td[h]=1, load_d[h]=1, d_in=1, mem_resp=1, load_lru=1 -> IDLE.
  - Miss: latch victim = decode(lru_out). way_dirty[victim]=1 -> WRITEBACK, else -> ALLOCATE.
- WRITEBACK:
  - pmem_write=1, pmemwdata_sel=victim, pmemaddr_sel=1+victim.
  - Hold until pmem_resp -> ALLOCATE.
- ALLOCATE:
  - pmem_read=1, pmemaddr_sel=0.
  - On the pmem_resp cycle: load_td[victim]=1, load_v[victim]=1, v_in=1, load_d[victim]=1, d_in=0 -> LOOKUP.
  - The re-lookup then hits and completes the access, including write merge and LRU update.
- Latency:
  - Hit: mem_resp in the 2nd cycle after the request is seen in IDLE.
  - Clean miss: pmem latency + 3 cycles.
  - Dirty miss: adds one writeback pmem latency.
- mem_resp is high for exactly one cycle. The arbiter must drop its request at that edge, so IDLE never double-issues.
- pmem_read and pmem_write are never both high.
- Both hold stable until pmem_resp. A pmem_resp outside WRITEBACK/ALLOCATE is ignored.

Test Plan:
- Cold read 0x1234 (index 3, tag 0x24), all ways invalid, lru_out=0 -> victim way0; no pmem_write; pmem_read with pmemaddr_sel=0; on pmem_resp load_td[0], load_v[0], v_in=1, d_in=0; then LOOKUP hit, mem_resp, lru_in=7'b0001011.
- Read hit way5 with lru_out=0 -> mem_resp 2 cycles after request, no pmem activity, lru_in=7'b0000000 with bit0=0, bit2=1, bit5=0 (i.e. 7'b0000100).
- Write hit way2 -> load_td[2]=1, load_d[2]=1, d_in=1, mem_resp same cycle, lru_in bits {0,1,4}={1,0,1}.
- Write miss, lru_out=7'b1000101 (victim way7), way_dirty[7]=1 -> pmem_write, pmemwdata_sel=7, pmemaddr_sel=8 until pmem_resp; then pmem_read, allocate way7, re-lookup hit writes with d_in=1.
- Assert rst_n=0 mid-ALLOCATE with pmem_read=1 -> pmem_read and all outputs 0 immediately (no clock edge); after release a new read starts cleanly from IDLE.
- Back-to-back: read hit, request dropped one cycle, write hit same set -> exactly two mem_resp pulses and two load_lru pulses; the second lru_in is derived from the updated lru_out.
